// File: rtl/clint_pkg.sv
// Shared constants, register-set type and helpers for the core-local interruptor.
// The register set is one packed struct so the top can use a single next-state record.
package clint_pkg;

   localparam logic [15:0] clint_msip      = 16'h0000;
   localparam logic [15:0] clint_mtimecmp  = 16'h4000;
   localparam logic [15:0] clint_mtimecmph = 16'h4004;
   localparam logic [15:0] clint_mtime     = 16'hBFF8;
   localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

   typedef struct packed {
      logic [63:0] mtime;
      logic [63:0] mtimecmp;
      logic [15:0] presc;
      logic        msip;
      logic        mtip;
      logic        ready;
      logic [31:0] rdata;
   } clint_reg_type;

   localparam clint_reg_type init_clint_reg = '{
      mtime:    64'd0,
      mtimecmp: 64'hFFFF_FFFF_FFFF_FFFF,
      presc:    16'd0,
      msip:     1'b0,
      mtip:     1'b0,
      ready:    1'b0,
      rdata:    32'd0
   };

   // Per-lane merge: each set strobe bit takes the matching byte of new_word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_if.sv
// Data-bus port of the CLINT: single-outstanding request with a one-cycle ready pulse.
interface clint_if;
   import clint_pkg::*;

   logic        clint_valid;
   logic [15:0] clint_addr;
   logic [31:0] clint_wdata;
   logic [3:0]  clint_wstrb;
   logic [31:0] clint_rdata;
   logic        clint_ready;

   modport master (
      output clint_valid,
      output clint_addr,
      output clint_wdata,
      output clint_wstrb,
      input  clint_rdata,
      input  clint_ready
   );

   modport slave (
      input  clint_valid,
      input  clint_addr,
      input  clint_wdata,
      input  clint_wstrb,
      output clint_rdata,
      output clint_ready
   );

endinterface

// File: rtl/clint.sv
// Core-local interruptor: mtime counter with prescaler, mtimecmp compare and msip bit,
// memory-mapped on the data bus and feeding mtip/msip/mtime to the csr stage.
module clint
   import clint_pkg::*;
#(
   parameter int RTC_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   clint_if.slave      bus,
   output logic        mtip,
   output logic        msip,
   output logic [63:0] mtime
);

   localparam logic [15:0] presc_max = 16'(RTC_DIV - 1);

   clint_reg_type reg_r;
   clint_reg_type next_s;
   logic          tick_s;
   logic          accept_s;
   logic [15:0]   word_addr_s;

   // Next-state: prescaler/mtime advance, compare, then any accepted bus access on top.
   always_comb begin
      next_s      = reg_r;
      tick_s      = (reg_r.presc == presc_max);
      accept_s    = bus.clint_valid & ~reg_r.ready;
      word_addr_s = bus.clint_addr & 16'hFFFC;

      if (tick_s) begin
         next_s.presc = 16'd0;
         next_s.mtime = reg_r.mtime + 64'd1;
      end else begin
         next_s.presc = reg_r.presc + 16'd1;
         next_s.mtime = reg_r.mtime;
      end

      next_s.mtip  = (reg_r.mtime >= reg_r.mtimecmp);
      next_s.ready = accept_s;
      next_s.rdata = 32'd0;

      if (accept_s && (bus.clint_wstrb == 4'b0000)) begin
         // Reads see the register values before this cycle's tick.
         case (word_addr_s)
            clint_msip:      next_s.rdata = {31'd0, reg_r.msip};
            clint_mtimecmp:  next_s.rdata = reg_r.mtimecmp[31:0];
            clint_mtimecmph: next_s.rdata = reg_r.mtimecmp[63:32];
            clint_mtime:     next_s.rdata = reg_r.mtime[31:0];
            clint_mtimeh:    next_s.rdata = reg_r.mtime[63:32];
            default:         next_s.rdata = 32'd0;
         endcase
      end else if (accept_s) begin
         // A write to either mtime half replaces the whole word, dropping a coincident tick.
         case (word_addr_s)
            clint_msip:      next_s.msip = bus.clint_wstrb[0] ? bus.clint_wdata[0] : reg_r.msip;
            clint_mtimecmp:  next_s.mtimecmp[31:0]  = merge_bytes(reg_r.mtimecmp[31:0],
                                                                  bus.clint_wdata, bus.clint_wstrb);
            clint_mtimecmph: next_s.mtimecmp[63:32] = merge_bytes(reg_r.mtimecmp[63:32],
                                                                  bus.clint_wdata, bus.clint_wstrb);
            clint_mtime:     next_s.mtime = {reg_r.mtime[63:32],
                                             merge_bytes(reg_r.mtime[31:0],
                                                         bus.clint_wdata, bus.clint_wstrb)};
            clint_mtimeh:    next_s.mtime = {merge_bytes(reg_r.mtime[63:32],
                                                         bus.clint_wdata, bus.clint_wstrb),
                                             reg_r.mtime[31:0]};
            default:         next_s.msip = reg_r.msip;
         endcase
      end else begin
         next_s.rdata = 32'd0;
      end
   end

   // Register set with synchronous active-low reset; reset also abandons any access.
   always_ff @(posedge clk) begin
      if (!rst) begin
         reg_r <= init_clint_reg;
      end else begin
         reg_r <= next_s;
      end
   end

   assign bus.clint_rdata = reg_r.rdata;
   assign bus.clint_ready = reg_r.ready;
   assign mtip            = reg_r.mtip;
   assign msip            = reg_r.msip;
   assign mtime           = reg_r.mtime;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: directed scenarios plus randomized register traffic
// checked against a timestamp-based model of mtime, mtimecmp and msip.
module tb_clint;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   clint_if bif ();
   clint_if bif4 ();

   logic        mtip, msip, mtip4, msip4;
   logic [63:0] mtime, mtime4;

   clint #(.RTC_DIV(1)) dut (
      .clk(clk), .rst(rst), .bus(bif.slave), .mtip(mtip), .msip(msip), .mtime(mtime)
   );

   clint #(.RTC_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bif4.slave), .mtip(mtip4), .msip(msip4), .mtime(mtime4)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   // Model: mtime = mt_base at edge count mt_cyc, plus one per later edge (RTC_DIV=1).
   logic [63:0] mt_base;
   int          mt_cyc;
   logic [63:0] cmp_val;
   logic        msip_val;
   logic        last_mtip, last_msip;

   function automatic logic [63:0] mt_at(input int c);
      return mt_base + 64'(c - mt_cyc);
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [15:0] a, input int c);
      logic [63:0] t;
      t = mt_at(c);
      case (a & 16'hFFFC)
         16'h0000: return {31'd0, msip_val};
         16'h4000: return cmp_val[31:0];
         16'h4004: return cmp_val[63:32];
         16'hBFF8: return t[31:0];
         16'hBFFC: return t[63:32];
         default:  return 32'd0;
      endcase
   endfunction

   task automatic do_reset();
      bif.clint_valid  = 1'b0; bif.clint_addr  = 16'd0; bif.clint_wdata  = 32'd0; bif.clint_wstrb  = 4'd0;
      bif4.clint_valid = 1'b0; bif4.clint_addr = 16'd0; bif4.clint_wdata = 32'd0; bif4.clint_wstrb = 4'd0;
      rst = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      mt_base = 64'd0; mt_cyc = cyc;
      cmp_val = 64'hFFFF_FFFF_FFFF_FFFF; msip_val = 1'b0;
   endtask

   // One access: drive, sample ready/rdata after the accept edge, update model, idle one cycle.
   task automatic bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic rdy);
      int          c_acc;
      logic [63:0] t;
      c_acc = cyc;
      t = mt_at(c_acc);
      bif.clint_valid = 1'b1; bif.clint_addr = a; bif.clint_wdata = d; bif.clint_wstrb = s;
      @(posedge clk); #1;
      rdy = bif.clint_ready; rd = bif.clint_rdata; last_mtip = mtip; last_msip = msip;
      bif.clint_valid = 1'b0; bif.clint_wstrb = 4'd0; bif.clint_wdata = 32'd0;
      if (s != 4'b0000) begin
         case (a & 16'hFFFC)
            16'h0000: if (s[0]) msip_val = d[0];
            16'h4000: cmp_val[31:0]  = lanes(cmp_val[31:0], d, s);
            16'h4004: cmp_val[63:32] = lanes(cmp_val[63:32], d, s);
            16'hBFF8: begin mt_base = {t[63:32], lanes(t[31:0], d, s)}; mt_cyc = c_acc + 1; end
            16'hBFFC: begin mt_base = {lanes(t[63:32], d, s), t[31:0]}; mt_cyc = c_acc + 1; end
            default: ;
         endcase
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic rdy;
      do_reset();
      checks++; if (mtime !== 64'd0) $display("FAIL reset_mtime: got %0h want 0", mtime); else passes++;
      checks++; if (mtip !== 1'b0) $display("FAIL reset_mtip: got %b want 0", mtip); else passes++;
      checks++; if (msip !== 1'b0) $display("FAIL reset_msip: got %b want 0", msip); else passes++;
      checks++; if (bif.clint_ready !== 1'b0 || bif.clint_rdata !== 32'd0)
         $display("FAIL reset_bus: got ready=%b rdata=%0h want 0/0", bif.clint_ready, bif.clint_rdata);
      else passes++;
      repeat (10) begin @(posedge clk); #1; end
      checks++; if (mtime !== 64'd10) $display("FAIL mtime_10: got %0d want 10", mtime); else passes++;
      bus(16'h4004, 32'd0, 4'b0000, rd, rdy);
      checks++; if (rdy !== 1'b1 || rd !== 32'hFFFF_FFFF)
         $display("FAIL read_cmph: got ready=%b rdata=%0h want 1/ffffffff", rdy, rd);
      else passes++;
   endtask

   task automatic test_div4();
      do_reset();
      for (int k = 0; k <= 40; k++) begin
         checks++; if (mtime4 !== 64'(k / 4))
            $display("FAIL div4_mtime k=%0d: got %0d want %0d", k, mtime4, k / 4);
         else passes++;
         if (k < 40) begin @(posedge clk); #1; end
      end
      checks++; if (mtime4 !== 64'd10 || mtip4 !== 1'b0 || msip4 !== 1'b0 ||
                    bif4.clint_ready !== 1'b0 || bif4.clint_rdata !== 32'd0)
         $display("FAIL div4_end: got mtime=%0d mtip=%b msip=%b want 10/0/0", mtime4, mtip4, msip4);
      else passes++;
   endtask

   task automatic test_compare();
      logic [31:0] rd; logic rdy; int c100;
      do_reset();
      bus(16'h4000, 32'h0000_0064, 4'b1111, rd, rdy);
      bus(16'h4004, 32'h0000_0000, 4'b1111, rd, rdy);
      c100 = mt_cyc + int'(64'd100 - mt_base);
      for (int i = 0; i < 200 && cyc < c100 + 6; i++) begin
         @(posedge clk); #1;
         checks++; if (mtip !== (cyc >= c100 + 1))
            $display("FAIL cmp_mtip cyc=%0d: got %b want %b", cyc - c100, mtip, cyc >= c100 + 1);
         else passes++;
         if (cyc == c100) begin
            checks++; if (mtime !== 64'd100) $display("FAIL cmp_mtime: got %0d want 100", mtime);
            else passes++;
         end
      end
      bus(16'h4004, 32'hFFFF_FFFF, 4'b1111, rd, rdy);
      checks++; if (last_mtip !== 1'b1) $display("FAIL cmp_fall_n1: got %b want 1", last_mtip); else passes++;
      checks++; if (mtip !== 1'b0) $display("FAIL cmp_fall_n2: got %b want 0", mtip); else passes++;
   endtask

   task automatic test_wrap();
      logic [31:0] rd, hi; logic rdy; logic [63:0] t;
      bus(16'hBFFC, 32'hFFFF_FFFF, 4'b1111, rd, rdy);
      bus(16'hBFF8, 32'hFFFF_FFFF, 4'b1111, rd, rdy);
      checks++; if (mtime !== 64'd0 || mtime !== mt_at(cyc))
         $display("FAIL wrap: got %0h want 0", mtime);
      else passes++;
      t = mt_at(cyc); hi = t[63:32];
      bus(16'hBFF8, 32'h1234_5678, 4'b1111, rd, rdy);
      checks++; if (mtime !== {hi, 32'h1234_5679})
         $display("FAIL tick_collision: got %0h want %0h", mtime, {hi, 32'h1234_5679});
      else passes++;
      bus(16'hBFF8, 32'hAB00_0000, 4'b1000, rd, rdy);
      checks++; if (mtime !== mt_at(cyc)) $display("FAIL mtime_strobe: got %0h want %0h", mtime, mt_at(cyc));
      else passes++;
   endtask

   task automatic test_msip();
      logic [31:0] rd; logic rdy;
      bus(16'h0000, 32'h0000_0001, 4'b0001, rd, rdy);
      checks++; if (last_msip !== 1'b1) $display("FAIL msip_set: got %b want 1", last_msip); else passes++;
      bus(16'h0000, 32'h0000_0000, 4'b0000, rd, rdy);
      checks++; if (rd !== 32'h0000_0001 || msip !== 1'b1)
         $display("FAIL msip_read: got rdata=%0h msip=%b want 1/1", rd, msip);
      else passes++;
      bus(16'h0000, 32'hFFFF_FFFE, 4'b0001, rd, rdy);
      checks++; if (msip !== 1'b0) $display("FAIL msip_clear: got %b want 0", msip); else passes++;
      bus(16'h1000, 32'hDEAD_BEEF, 4'b1111, rd, rdy);
      bus(16'h1000, 32'h0000_0000, 4'b0000, rd, rdy);
      checks++; if (rdy !== 1'b1 || rd !== 32'd0)
         $display("FAIL unmapped: got ready=%b rdata=%0h want 1/0", rdy, rd);
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_pat; logic [31:0] exp_rd;
      exp_pat = 4'b0101;
      exp_rd  = model_read(16'h4004, cyc);
      bif.clint_valid = 1'b1; bif.clint_addr = 16'h4004; bif.clint_wstrb = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i == 2) bif.clint_valid = 1'b0;
         checks++; if (bif.clint_ready !== exp_pat[i] || (exp_pat[i] && bif.clint_rdata !== exp_rd))
            $display("FAIL b2b sample %0d: got ready=%b rdata=%0h want %b/%0h",
                     i, bif.clint_ready, bif.clint_rdata, exp_pat[i], exp_rd);
         else passes++;
      end
   endtask

   task automatic test_reset_mid();
      bif.clint_valid = 1'b1; bif.clint_addr = 16'h4000; bif.clint_wstrb = 4'b0000;
      @(posedge clk); #1;
      checks++; if (bif.clint_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", bif.clint_ready);
      else passes++;
      rst = 1'b0; bif.clint_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (bif.clint_ready !== 1'b0 || bif.clint_rdata !== 32'd0)
         $display("FAIL rstmid_clear: got ready=%b rdata=%0h want 0/0", bif.clint_ready, bif.clint_rdata);
      else passes++;
      bif.clint_valid = 1'b1; bif.clint_addr = 16'h0000; bif.clint_wdata = 32'd1; bif.clint_wstrb = 4'b0001;
      @(posedge clk); #1;
      bif.clint_valid = 1'b0; bif.clint_wstrb = 4'b0000; rst = 1'b1;
      mt_base = 64'd0; mt_cyc = cyc; cmp_val = 64'hFFFF_FFFF_FFFF_FFFF; msip_val = 1'b0;
      checks++; if (msip !== 1'b0 || bif.clint_ready !== 1'b0 || mtime !== 64'd0)
         $display("FAIL rstmid_nowrite: got msip=%b ready=%b mtime=%0h want 0/0/0", msip, bif.clint_ready, mtime);
      else passes++;
   endtask

   task automatic test_random();
      logic [15:0] a; logic [31:0] d, rd, exp; logic [3:0] s; logic rdy;
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 5))
            0:       a = 16'h0000;
            1:       a = 16'h4000;
            2:       a = 16'h4004;
            3:       a = 16'hBFF8;
            4:       a = 16'hBFFC;
            default: a = {4'h1, 10'($urandom_range(0, 1023)), 2'b00};
         endcase
         a = a | 16'($urandom_range(0, 3));
         s = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         d = $urandom;
         exp = model_read(a, cyc);
         bus(a, d, s, rd, rdy);
         checks++; if (rdy !== 1'b1) $display("FAIL rnd_ready n=%0d: got %b want 1", n, rdy); else passes++;
         if (s == 4'b0000) begin
            checks++; if (rd !== exp) $display("FAIL rnd_read n=%0d a=%0h: got %0h want %0h", n, a, rd, exp);
            else passes++;
         end
         checks++; if (msip !== msip_val || mtime !== mt_at(cyc))
            $display("FAIL rnd_state n=%0d: got msip=%b mtime=%0h want %b/%0h", n, msip, mtime, msip_val, mt_at(cyc));
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_div4();
      test_compare();
      test_wrap();
      test_msip();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/clint.md
# clint

Core-local interruptor: machine timer and software-interrupt source for the single hart. Holds the 64-bit mtime counter, the mtimecmp compare register and the msip bit, all memory-mapped on the data bus. Drives the `mtip`, `msip` and `mtime[63:0]` inputs of the csr stage, which latches them into mip and reports them through `time`.

## Interface
Parameters:
- `RTC_DIV`, default 1: core-clock cycles per mtime tick; legal range 1..65535.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `clint_valid` in 1: bus request; held high until `clint_ready`.
- `clint_addr` in 16: byte offset within the CLINT window; bits [1:0] ignored.
- `clint_wdata` in 32: write data.
- `clint_wstrb` in 4: byte strobes; 0 means read.
- `clint_rdata` out 32: read data, valid while `clint_ready`=1.
- `clint_ready` out 1: one-cycle completion pulse.
- `mtip` out 1: timer interrupt pending, to csr.
- `msip` out 1: software interrupt pending, to csr.
- `mtime` out 64: current mtime, to csr.

## Operation
- Register map, word offsets:
  - 0x0000: msip; bit 0 only, other bits read 0.
  - 0x4000: mtimecmp[31:0].
  - 0x4004: mtimecmp[63:32].
  - 0xBFF8: mtime[31:0].
  - 0xBFFC: mtime[63:32].
- Writes honour byte strobes per byte lane.
- Unmapped offset: write ignored, read returns 0, `clint_ready` still pulses, no error.
- Prescaler: counter 0..RTC_DIV-1. mtime increments by 1 in the cycle the prescaler reaches RTC_DIV-1, and the prescaler returns to 0. RTC_DIV=1 means mtime increments every cycle.
- mtime is 64-bit unsigned and wraps from 2^64-1 to 0 with no flag.
- Write to either mtime half in the same cycle as a tick: the written half takes the written bytes, the other half holds, and that tick is dropped. The prescaler is unaffected.
- `mtip` is a registered compare: `mtip` <= (mtime >= mtimecmp), 64-bit unsigned, evaluated every cycle on the current register values.
- Software must write mtimecmp high half = 0xFFFFFFFF first to avoid a spurious `mtip`. The hardware does nothing special about this.
- `msip` output equals the msip register bit directly.

Reset values:
- mtime = 0, prescaler = 0, mtimecmp = 0xFFFFFFFF_FFFFFFFF, msip = 0.
- Outputs: `mtip` = 0, `clint_ready` = 0, `clint_rdata` = 0.

## Timing
- Handshake: the request is accepted in the first cycle with `clint_valid`=1 and no access in flight.
- Register write and read sampling happen in that cycle.
- `clint_ready`=1 with `clint_rdata` in the next cycle; `clint_rdata` returns to 0 otherwise.
- In the `clint_ready` cycle a still-high `clint_valid` is not a new request. Minimum spacing is 2 cycles per access.
- Read of mtime returns the value before any same-cycle increment.
- Write to mtimecmp or mtime in cycle N: the new value is visible at the register in N+1, and `mtip` reflects it in N+2.
- Tick making mtime == mtimecmp in cycle N: `mtip`=1 from N+2. The csr stage adds one more cycle before mip.mtip.
- msip write in cycle N: `msip`=1 in N+1.
- Reset mid-access: an in-flight access is abandoned, `clint_ready` is 0 in the cycle after reset, and no write lands.

## Structure
- Constants in the shared constants package: `clint_msip`=16'h0000, `clint_mtimecmp`=16'h4000, `clint_mtimecmph`=16'h4004, `clint_mtime`=16'hBFF8, `clint_mtimeh`=16'hBFFC.
- A `clint_reg_type` struct for the register set goes in the wires package, with an `init_clint_reg` reset constant.
- Base-address decode lives in the SoC interconnect, not here.
- No sub-module: the prescaler, register file and comparator are inline in one module.

## Test plan
- Reset, RTC_DIV=1:
  - After reset: `mtip`=0, `msip`=0, `mtime`=0.
  - After 10 cycles: `mtime`=10.
  - Reading 0x4004 returns 0xFFFFFFFF.
- RTC_DIV=4: `mtime` increments exactly once per 4 cycles. Over 40 cycles, `mtime`=10.
- Compare, RTC_DIV=1:
  - Write mtimecmp = 0x00000000_00000064.
  - `mtip` rises 2 cycles after mtime reaches 100 and stays high.
  - Write mtimecmp high half = 0xFFFFFFFF: `mtip` falls 2 cycles later.
- Wrap and write collision:
  - Write mtime low = 0xFFFFFFFF and high = 0xFFFFFFFF; after 1 more tick, mtime = 0.
  - Write to the low half on a tick cycle: low half = written value, high half unchanged.
- msip and strobes:
  - Write 0x1 to 0x0000 with `clint_wstrb`=4'b0001: `msip`=1 next cycle, readback 0x00000001.
  - Write with `clint_wstrb`=4'b0000 is a read, no change.
  - Unmapped 0x1000: ready pulses, rdata=0.
- Handshake:
  - `clint_valid` held 3 cycles gives exactly one `clint_ready` pulse per access, spaced 2 cycles apart.
  - Asserting `rst`=0 during the ready cycle clears `clint_ready` next cycle.
